// File: rtl/ads8681_spi_ctrl.sv
// ads8681_spi_ctrl
// Conversion/readout engine for the ADS8681 16-bit ADC. Each accepted start
// waits out the conversion time, then shifts one frame with CS low: the
// latched command goes out on SDI while SDO is captured. Raising CS at the
// end of the frame launches the next conversion and publishes the data.
// SCLK is a registered output advanced by a phase counter on clk_in; it is
// never used as a clock.
//
// Ports:
//   clk_in      system clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle readout request, ignored while busy
//   cmd_word    command frame, latched when start is accepted
//   busy        high from start acceptance through the data_valid cycle
//   data_valid  one-cycle pulse, data_out/rx_frame updated
//   data_out    conversion result (rx_frame[31:16])
//   rx_frame    full captured SDO frame
//   adc_cs_n    ADC chip select, active low
//   adc_sclk    ADC serial clock, idle low
//   adc_sdi     ADC serial data in, MSB first
//   adc_sdo     ADC serial data out
//
// state | meaning
// IDLE  | CS high, waiting for start
// WAIT  | CS high, waiting for conv_timer to reach CONV_CYCLES
// XFER  | CS low, shifting FRAME_BITS bits of CLK_DIV cycles each
// DONE  | CS high again, data_valid pulse, results published
module ads8681_spi_ctrl #(
    parameter int CLK_DIV     = 4,
    parameter int CONV_CYCLES = 67,
    parameter int FRAME_BITS  = 32
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] cmd_word,
    output logic        busy,
    output logic        data_valid,
    output logic [15:0] data_out,
    output logic [31:0] rx_frame,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int TW = $clog2(CONV_CYCLES + 1);

    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(CLK_DIV / 2);
    localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [TW-1:0] T_SAT = TW'(CONV_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_phase;
    logic [PW-1:0]   w_phase_nxt;
    logic [BW-1:0]   r_bit;
    logic [TW-1:0]   r_timer;
    logic [31:0]     r_tx;
    logic [31:0]     r_rx;
    logic            r_cs_n;
    logic            r_cs_n_d;
    logic            r_sclk;
    logic            r_sdi;
    logic            r_busy;
    logic            r_dv;
    logic [15:0]     r_data_out;
    logic [31:0]     r_rx_frame;
    logic            w_ph_last;

    assign w_ph_last = (r_phase == PH_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = '0;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_WAIT;
            S_WAIT: if (r_timer == T_SAT) w_state_nxt = S_XFER;
            S_XFER: begin
                if (!w_ph_last) w_phase_nxt = r_phase + 1'b1;
                if (w_ph_last && (r_bit == BIT_LAST)) w_state_nxt = S_DONE;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_bit      <= '0;
            r_timer    <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cs_n     <= 1'b1;
            r_cs_n_d   <= 1'b1;
            r_sclk     <= 1'b0;
            r_sdi      <= 1'b0;
            r_busy     <= 1'b0;
            r_dv       <= 1'b0;
            r_data_out <= '0;
            r_rx_frame <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_cs_n   <= (w_state_nxt != S_XFER);
            r_cs_n_d <= r_cs_n;
            r_sclk   <= (w_state_nxt == S_XFER) && (w_phase_nxt >= PH_HALF);
            r_busy   <= (w_state_nxt != S_IDLE);
            r_dv     <= (w_state_nxt == S_DONE);

            if (r_state != S_XFER)
                r_bit <= '0;
            else if (w_ph_last)
                r_bit <= r_bit + 1'b1;

            // CS rising edge restarts the conversion-time count.
            if (r_cs_n && !r_cs_n_d)
                r_timer <= '0;
            else if (r_cs_n && (r_timer != T_SAT))
                r_timer <= r_timer + 1'b1;

            if ((r_state == S_IDLE) && start)
                r_tx <= cmd_word;
            else if ((r_state == S_XFER) && w_ph_last)
                r_tx <= {r_tx[30:0], 1'b0};

            // SDI moves only at phase 0; on a bit boundary the register
            // is shifting in the same edge, so take the next MSB directly.
            if (w_state_nxt == S_XFER)
                r_sdi <= ((r_state == S_XFER) && w_ph_last) ? r_tx[30] : r_tx[31];
            else
                r_sdi <= 1'b0;

            // Sample on the edge that raises SCLK.
            if ((r_state == S_XFER) && (r_phase == PH_RISE))
                r_rx <= {r_rx[30:0], adc_sdo};

            if (w_state_nxt == S_DONE) begin
                r_rx_frame <= r_rx;
                r_data_out <= r_rx[31:16];
            end
        end
    end

    assign busy       = r_busy;
    assign data_valid = r_dv;
    assign data_out   = r_data_out;
    assign rx_frame   = r_rx_frame;
    assign adc_cs_n   = r_cs_n;
    assign adc_sclk   = r_sclk;
    assign adc_sdi    = r_sdi;

endmodule

// File: tb/tb_ads8681_spi_ctrl.sv
module tb_ads8681_spi_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] cmd_word;
    logic        busy;
    logic        data_valid;
    logic [15:0] data_out;
    logic [31:0] rx_frame;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_sdi;
    logic        adc_sdo = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    ads8681_spi_ctrl #(.CLK_DIV(4), .CONV_CYCLES(8), .FRAME_BITS(32)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .start(start), .cmd_word(cmd_word),
        .busy(busy), .data_valid(data_valid), .data_out(data_out),
        .rx_frame(rx_frame), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
        .adc_sdi(adc_sdi), .adc_sdo(adc_sdo)
    );

    always #5 clk_in = ~clk_in;

    // ADC model: MSB presented at CS fall, next bit launched on SCLK fall,
    // SDI captured on SCLK rise.
    logic [31:0] sdo_pat = 32'h0;
    logic [31:0] sdi_cap = 32'h0;
    int sdo_idx = 0;

    always @(negedge adc_cs_n) begin
        sdo_idx = 31;
        adc_sdo = sdo_pat[31];
        sdi_cap = 32'h0;
    end

    always @(negedge adc_sclk) begin
        if (!adc_cs_n && sdo_idx > 0) begin
            sdo_idx = sdo_idx - 1;
            adc_sdo = sdo_pat[sdo_idx];
        end
    end

    always @(posedge adc_sclk) sdi_cap = {sdi_cap[30:0], adc_sdi};

    // Cycle monitor sampled on the inactive edge.
    int cyc = 0, fall_cyc = 0, rise_cyc = 0, busy_cyc = 0, dv_cyc = 0;
    int dv_cnt = 0, hi_cnt = 0, lo_cnt = 0, sclk_rises = 0, shape_err = 0;
    int high_len = 0;
    logic prev_cs = 1'b1, prev_busy = 1'b0, prev_sclk = 1'b0;

    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (!adc_cs_n && prev_cs) begin
            fall_cyc = cyc;
            high_len = cyc - rise_cyc;
        end
        if (adc_cs_n && !prev_cs) rise_cyc = cyc;
        if (busy && !prev_busy) busy_cyc = cyc;
        if (!adc_cs_n) begin
            if (adc_sclk) hi_cnt = hi_cnt + 1;
            else lo_cnt = lo_cnt + 1;
            if (adc_sclk !== (((cyc - fall_cyc) % 4) >= 2)) shape_err = shape_err + 1;
        end
        if (adc_sclk && !prev_sclk) sclk_rises = sclk_rises + 1;
        if (data_valid) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
        end
        prev_cs = adc_cs_n;
        prev_busy = busy;
        prev_sclk = adc_sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wait_dv(input string tag, input int lim);
        int k;
        k = 0;
        while (data_valid !== 1'b1 && k < lim) begin
            @(negedge clk_in);
            k++;
        end
        chk(tag, 32'(k < lim), 32'd1);
    endtask

    task automatic clr_mon();
        hi_cnt = 0;
        lo_cnt = 0;
        sclk_rises = 0;
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        cmd_word = 32'h0;
        tick(3);
        chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
        chk("rst_sclk", 32'(adc_sclk), 32'd0);
        chk("rst_sdi", 32'(adc_sdi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_rx_frame", rx_frame, 32'd0);
        rst_n = 1'b1;

        // Frame 1: NOP command, timer already saturated.
        tick(17);
        sdo_pat = 32'hA5A5_3C3C;
        clr_mon();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("f1_busy_next", 32'(busy), 32'd1);
        wait_dv("f1_dv_timeout", 400);
        tick(1);
        chk("f1_rx_frame", rx_frame, 32'hA5A5_3C3C);
        chk("f1_data_out", 32'(data_out), 32'h0000_A5A5);
        chk("f1_sdi", sdi_cap, 32'h0);
        chk("f1_wait_len", 32'(fall_cyc - busy_cyc), 32'd1);
        chk("f1_xfer_len", 32'(dv_cyc - fall_cyc), 32'd128);
        chk("f1_latency", 32'(dv_cyc - busy_cyc), 32'd129);
        chk("f1_sclk_rises", 32'(sclk_rises), 32'd32);
        chk("f1_sclk_hi", 32'(hi_cnt), 32'd64);
        chk("f1_sclk_lo", 32'(lo_cnt), 32'd64);
        chk("f1_dv_cnt", 32'(dv_cnt), 32'd1);
        chk("f1_busy_after", 32'(busy), 32'd0);
        chk("f1_dv_after", 32'(data_valid), 32'd0);
        chk("f1_cs_after", 32'(adc_cs_n), 32'd1);

        // Frame 2: real command, changed mid-frame; timer restarted at CS rise.
        sdo_pat = 32'h1234_ABCD;
        cmd_word = 32'hD014_0003;
        clr_mon();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(40);
        cmd_word = 32'hFFFF_FFFF;
        wait_dv("f2_dv_timeout", 400);
        tick(1);
        chk("f2_sdi", sdi_cap, 32'hD014_0003);
        chk("f2_rx_frame", rx_frame, 32'h1234_ABCD);
        chk("f2_data_out", 32'(data_out), 32'h0000_1234);
        chk("f2_wait_len", 32'(fall_cyc - busy_cyc), 32'd8);
        chk("f2_sclk_rises", 32'(sclk_rises), 32'd32);
        chk("f2_dv_cnt", 32'(dv_cnt), 32'd2);

        // Frames 3+4: start held high throughout.
        clr_mon();
        start = 1'b1;
        wait_dv("f3_dv_timeout", 400);
        tick(1);
        wait_dv("f4_dv_timeout", 400);
        start = 1'b0;
        tick(1);
        chk("b2b_dv_cnt", 32'(dv_cnt), 32'd4);
        chk("b2b_cs_high", 32'(high_len), 32'd10);
        chk("b2b_wait_len", 32'(fall_cyc - busy_cyc), 32'd8);
        chk("b2b_sdi", sdi_cap, 32'hFFFF_FFFF);
        chk("b2b_rx_frame", rx_frame, 32'h1234_ABCD);
        chk("b2b_sclk_rises", 32'(sclk_rises), 32'd64);
        chk("b2b_busy_after", 32'(busy), 32'd0);

        // Frame 5: long idle gap, timer saturated.
        tick(49);
        sdo_pat = 32'h5A5A_C3C3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_dv("f5_dv_timeout", 400);
        tick(1);
        chk("f5_wait_len", 32'(fall_cyc - busy_cyc), 32'd1);
        chk("f5_latency", 32'(dv_cyc - busy_cyc), 32'd129);
        chk("f5_rx_frame", rx_frame, 32'h5A5A_C3C3);
        chk("f5_dv_cnt", 32'(dv_cnt), 32'd5);

        // Reset during bit 10 of a frame.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        k = 0;
        while (adc_cs_n !== 1'b0 && k < 50) begin
            tick(1);
            k++;
        end
        chk("rm_cs_fall_timeout", 32'(k < 50), 32'd1);
        tick(40);
        rst_n = 1'b0;
        #1;
        chk("rm_cs_n", 32'(adc_cs_n), 32'd1);
        chk("rm_sclk", 32'(adc_sclk), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_rx_frame", rx_frame, 32'd0);
        chk("rm_data_out", 32'(data_out), 32'd0);
        tick(3);
        chk("rm_no_dv", 32'(dv_cnt), 32'd5);

        sdo_pat = 32'h0F0F_55AA;
        cmd_word = 32'h8000_0001;
        clr_mon();
        rst_n = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_dv("f6_dv_timeout", 400);
        tick(1);
        chk("f6_rx_frame", rx_frame, 32'h0F0F_55AA);
        chk("f6_data_out", 32'(data_out), 32'h0000_0F0F);
        chk("f6_sdi", sdi_cap, 32'h8000_0001);
        chk("f6_wait_len", 32'(fall_cyc - busy_cyc), 32'd8);
        chk("f6_sclk_hi", 32'(hi_cnt), 32'd64);
        chk("f6_dv_cnt", 32'(dv_cnt), 32'd6);
        chk("sclk_shape_err", 32'(shape_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
